// File: rtl/debounce_arr_pkg.sv
// Shared defaults for the debounce array.
// Channel logic derives its own threshold from BITS.
package debounce_arr_pkg;

    localparam int DEF_COUNT = 8;
    localparam int DEF_BITS  = 16;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchronizer,
// stability counter and registered edge pulses.
module debounce_channel #(
    parameter int BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam logic [BITS-1:0] MAX = {BITS{1'b1}};

    logic            sync1;
    logic            sync2;
    logic [BITS-1:0] cnt;

    logic            cnt_nx;
    logic [BITS-1:0] cnt_d;
    logic            out_d;
    logic            rise_d;
    logic            fall_d;

    assign cnt_nx = 1'b0;

    always_comb begin
        cnt_d  = cnt;
        out_d  = out;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (sync2 == out) begin
            cnt_d = '0;
        end else if (tick) begin
            // Mismatch held through a full MAX count: accept it.
            if (cnt == MAX) begin
                cnt_d  = '0;
                out_d  = sync2;
                rise_d = sync2;
                fall_d = ~sync2;
            end else begin
                cnt_d = cnt + {{(BITS-1){cnt_nx}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            out   <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            cnt   <= cnt_d;
            out   <= out_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

endmodule

// File: rtl/debounce_arr.sv
// Array of independent debounce channels sharing
// clock, reset and counting enable.
module debounce_arr
    import debounce_arr_pkg::*;
#(
    parameter int COUNT = DEF_COUNT,
    parameter int BITS  = DEF_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [COUNT-1:0] in,
    output logic [COUNT-1:0] out,
    output logic [COUNT-1:0] rise,
    output logic [COUNT-1:0] fall
);

    for (genvar i = 0; i < COUNT; i++) begin : g_ch
        debounce_channel #(
            .BITS (BITS)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .in    (in[i]),
            .out   (out[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

endmodule

// File: tb/tb_debounce_arr.sv
// Directed bench for debounce_arr with two channels
// and a 2-bit counter (accept on edge 6).
module tb_debounce_arr;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [1:0] in;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;

    int n_cmp = 0;
    int n_err = 0;

    debounce_arr #(
        .COUNT (2),
        .BITS  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .in    (in),
        .out   (out),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag,
                         input logic [1:0] obs,
                         input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] v);
        reset = 1'b1;
        in    = v;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b1;
        in    = 2'b11;

        // Reset with inputs already high
        step(3);
        check("rst_out", out, 2'b00);
        check("rst_rise", rise, 2'b00);
        check("rst_fall", fall, 2'b00);
        reset = 1'b0;
        step(5);
        check("rel_out5", out, 2'b00);
        check("rel_rise5", rise, 2'b00);
        step(1);
        check("rel_rise6", rise, 2'b11);
        check("rel_out6", out, 2'b11);
        step(1);
        check("rel_rise7", rise, 2'b00);
        check("rel_out7", out, 2'b11);

        // Clean rise then fall on channel 0
        do_reset(2'b00);
        in = 2'b01;
        step(5);
        check("clr_out5", out, 2'b00);
        check("clr_rise5", rise, 2'b00);
        step(1);
        check("clr_out6", out, 2'b01);
        check("clr_rise6", rise, 2'b01);
        check("clr_fall6", fall, 2'b00);
        step(1);
        check("clr_rise7", rise, 2'b00);
        in = 2'b00;
        step(5);
        check("clf_out5", out, 2'b01);
        check("clf_fall5", fall, 2'b00);
        step(1);
        check("clf_out6", out, 2'b00);
        check("clf_fall6", fall, 2'b01);
        check("clf_rise6", rise, 2'b00);
        step(1);
        check("clf_fall7", fall, 2'b00);

        // Three-cycle glitch is rejected
        in = 2'b01;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) in = 2'b00;
            step(1);
            check("gl_out", out, 2'b00);
            check("gl_rise", rise, 2'b00);
            check("gl_fall", fall, 2'b00);
        end

        // Bounce: high 2, low 1, high held
        in = 2'b01;
        step(2);
        in = 2'b00;
        step(1);
        in = 2'b01;
        step(5);
        check("bn_out5", out, 2'b00);
        check("bn_rise5", rise, 2'b00);
        step(1);
        check("bn_out6", out, 2'b01);
        check("bn_rise6", rise, 2'b01);
        step(1);

        // Tick every 4th edge on channel 1
        in = 2'b11;
        for (int e = 1; e <= 16; e++) begin
            tick = (e % 4 == 0);
            step(1);
            if (e < 16) begin
                check("tk_out", out, 2'b01);
                check("tk_rise", rise, 2'b00);
            end else begin
                check("tk_out16", out, 2'b11);
                check("tk_rise16", rise, 2'b10);
            end
        end
        tick = 1'b1;
        step(1);
        check("tk_rise17", rise, 2'b00);

        // Reset in the middle of a count
        do_reset(2'b00);
        in = 2'b01;
        step(3);
        step(1);
        reset = 1'b1;
        step(2);
        check("rm_out", out, 2'b00);
        check("rm_rise", rise, 2'b00);
        reset = 1'b0;
        step(5);
        check("rm_out5", out, 2'b00);
        check("rm_rise5", rise, 2'b00);
        step(1);
        check("rm_out6", out, 2'b01);
        check("rm_rise6", rise, 2'b01);
        step(1);
        check("rm_rise7", rise, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
